// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like slave port between inst and data masters, routing in-order responses via an owner FIFO.
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      inst_req,
  input  logic                      inst_wr,
  input  logic [1:0]                inst_size,
  input  logic [3:0]                inst_wstrb,
  input  logic [31:0]               inst_addr,
  input  logic [31:0]               inst_wdata,
  output logic                      inst_addr_ok,
  output logic                      inst_data_ok,
  output logic [31:0]               inst_rdata,
  input  logic                      data_req,
  input  logic                      data_wr,
  input  logic [1:0]                data_size,
  input  logic [3:0]                data_wstrb,
  input  logic [31:0]               data_addr,
  input  logic [31:0]               data_wdata,
  output logic                      data_addr_ok,
  output logic                      data_data_ok,
  output logic [31:0]               data_rdata,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [1:0]                s_size,
  output logic [3:0]                s_wstrb,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [31:0]               s_rdata,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, next_state;
  logic [DEPTH-1:0] owner_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [SW-1:0] starve, starve_nxt;
  logic ready, lock_owner, win, gnt, full, empty, hs, pop, head;
  always_comb begin
    win = (inst_req && (starve == SW'(STARVE_LIMIT) || !data_req)) ? 1'b0 : 1'b1;
    gnt = (state == LOCKED) ? lock_owner : win;
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    s_req = ready && !full && (gnt ? data_req : inst_req);
    hs = s_req && s_addr_ok;
    pop = s_data_ok && !empty;
    head = owner_q[rd_ptr];
    next_state = (state == IDLE) ? ((s_req && !s_addr_ok) ? LOCKED : IDLE) : (hs ? IDLE : LOCKED);
    starve_nxt = (!inst_req || (hs && !gnt)) ? '0 :
                 (gnt && starve != SW'(STARVE_LIMIT)) ? starve + SW'(1) : starve;
  end
  // Fields are gated by ready so every output reads 0 while held in reset.
  assign s_wr         = ready && (gnt ? data_wr : inst_wr);
  assign s_size       = ready ? (gnt ? data_size : inst_size) : '0;
  assign s_wstrb      = ready ? (gnt ? data_wstrb : inst_wstrb) : '0;
  assign s_addr       = ready ? (gnt ? data_addr : inst_addr) : '0;
  assign s_wdata      = ready ? (gnt ? data_wdata : inst_wdata) : '0;
  assign inst_addr_ok = hs && !gnt;
  assign data_addr_ok = hs && gnt;
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = inst_data_ok ? s_rdata : '0;
  assign data_rdata   = data_data_ok ? s_rdata : '0;
  assign outstanding  = count;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      lock_owner <= 1'b0;
      ready      <= 1'b0;
      owner_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve     <= '0;
      resp_err   <= 1'b0;
    end else begin
      state  <= next_state;
      ready  <= 1'b1;
      starve <= starve_nxt;
      count  <= count + (AW+1)'(hs) - (AW+1)'(pop);
      if (state == IDLE && s_req && !s_addr_ok) lock_owner <= gnt;
      if (hs) begin
        owner_q[wr_ptr] <= gnt;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (s_data_ok && empty) resp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: vector table plus hand sequences, responses checked against an owner scoreboard.
module tb_sram_like_arbiter;
  localparam logic [31:0] IA = 32'h0000_1000;
  localparam logic [31:0] DA = 32'h0000_2000;
  logic clk = 1'b0, resetn = 1'b0;
  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 1;
  logic [1:0] inst_size = 2'd2, data_size = 2'd1;
  logic [3:0] inst_wstrb = 4'hf, data_wstrb = 4'h3;
  logic [31:0] inst_addr = IA, data_addr = DA, inst_wdata = 32'hAAAA_0000, data_wdata = 32'hBBBB_0000;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic s_req, s_wr, s_addr_ok = 0, s_data_ok = 0;
  logic [1:0] s_size;
  logic [3:0] s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata = 0;
  logic [2:0] outstanding;
  logic resp_err;
  int n_cmp = 0, n_bad = 0;
  bit exp_q[$];

  typedef struct {
    logic i, d, aok, dok;
    logic [31:0] rd;
    logic sreq, own, iaok, daok, idok, ddok;
    int outst;
  } vec_t;

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cycle_chk(input vec_t v, input string tag);
    bit o;
    inst_req = v.i; data_req = v.d; s_addr_ok = v.aok; s_data_ok = v.dok; s_rdata = v.rd;
    #2;
    chk({tag, ".s_req"}, s_req, v.sreq);
    if (v.sreq) begin
      chk({tag, ".s_addr"}, s_addr, v.own ? DA : IA);
      chk({tag, ".s_wr"}, s_wr, v.own);
      chk({tag, ".s_size"}, s_size, v.own ? 2'd1 : 2'd2);
    end
    chk({tag, ".inst_addr_ok"}, inst_addr_ok, v.iaok);
    chk({tag, ".data_addr_ok"}, data_addr_ok, v.daok);
    chk({tag, ".inst_data_ok"}, inst_data_ok, v.idok);
    chk({tag, ".data_data_ok"}, data_data_ok, v.ddok);
    chk({tag, ".outstanding"}, outstanding, v.outst);
    if (v.dok) begin
      if (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        chk({tag, ".sb_inst_rdata"}, inst_rdata, o ? 32'h0 : v.rd);
        chk({tag, ".sb_data_rdata"}, data_rdata, o ? v.rd : 32'h0);
      end else begin
        chk({tag, ".sb_empty_inst_ok"}, inst_data_ok, 1'b0);
        chk({tag, ".sb_empty_data_ok"}, data_data_ok, 1'b0);
      end
    end
    if (v.iaok || v.daok) exp_q.push_back(v.own);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[22];
    vec_t v;
    int s, m, first_inst;
    bit own;
    tbl[0]  = '{1,1,1,0,32'h0,         1,1,0,1,0,0,0};
    tbl[1]  = '{1,0,1,0,32'h0,         1,0,1,0,0,0,1};
    tbl[2]  = '{0,0,0,1,32'h1111_1111, 0,0,0,0,0,1,2};
    tbl[3]  = '{0,0,0,1,32'h2222_2222, 0,0,0,0,1,0,1};
    tbl[4]  = '{1,0,0,0,32'h0,         1,0,0,0,0,0,0};
    tbl[5]  = '{1,1,0,0,32'h0,         1,0,0,0,0,0,0};
    tbl[6]  = '{1,1,0,0,32'h0,         1,0,0,0,0,0,0};
    tbl[7]  = '{1,1,1,0,32'h0,         1,0,1,0,0,0,0};
    tbl[8]  = '{0,1,1,0,32'h0,         1,1,0,1,0,0,1};
    tbl[9]  = '{0,1,0,0,32'h0,         1,1,0,0,0,0,2};
    tbl[10] = '{1,1,0,0,32'h0,         1,1,0,0,0,0,2};
    tbl[11] = '{1,1,1,0,32'h0,         1,1,0,1,0,0,2};
    tbl[12] = '{1,0,1,1,32'h3333_3333, 1,0,1,0,1,0,3};
    tbl[13] = '{0,1,1,0,32'h0,         1,1,0,1,0,0,3};
    tbl[14] = '{1,1,1,0,32'h0,         0,1,0,0,0,0,4};
    tbl[15] = '{1,1,1,1,32'h4444_4444, 0,1,0,0,0,1,4};
    tbl[16] = '{1,1,1,0,32'h0,         1,1,0,1,0,0,3};
    tbl[17] = '{1,0,0,1,32'h5555_5555, 0,0,0,0,0,1,4};
    tbl[18] = '{1,0,1,1,32'h6666_6666, 1,0,1,0,1,0,3};
    tbl[19] = '{0,0,0,1,32'h7777_7777, 0,0,0,0,0,1,3};
    tbl[20] = '{0,0,0,1,32'h8888_8888, 0,0,0,0,0,1,2};
    tbl[21] = '{0,0,0,1,32'h9999_9999, 0,0,0,0,1,0,1};
    inst_req = 1;
    #12;
    chk("rst.s_req", s_req, 1'b0);
    chk("rst.s_addr", s_addr, 32'h0);
    chk("rst.outstanding", outstanding, 3'd0);
    chk("rst.resp_err", resp_err, 1'b0);
    resetn = 1;
    #1;
    chk("rel.s_req_first_edge", s_req, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 22; k++) cycle_chk(tbl[k], $sformatf("vec%0d", k));
    chk("vec.queue_drained", exp_q.size(), 0);
    // Data keeps winning until inst has been refused STARVE_LIMIT times.
    s = 0; m = 0; first_inst = -1;
    for (int k = 0; k < 20; k++) begin
      own = (s == 8) ? 1'b0 : 1'b1;
      v = '{1, 1, 1, m > 0, 32'hA000_0000 + k, 1, own, !own, own,
            (m > 0) ? !exp_q[0] : 1'b0, (m > 0) ? exp_q[0] : 1'b0, m};
      cycle_chk(v, $sformatf("starve%0d", k));
      if (!own && first_inst < 0) first_inst = k;
      s = own ? s + 1 : 0;
      m = (m > 0) ? m : m + 1;
    end
    chk("starve.first_inst_cycle", first_inst, 8);
    v = '{0, 0, 0, 1, 32'hB000_0001, 0, 0, 0, 0, !exp_q[0], exp_q[0], 1};
    cycle_chk(v, "starve_drain");
    chk("starve.drained", outstanding, 3'd0);
    chk("starve.no_err", resp_err, 1'b0);
    cycle_chk('{0,0,0,1,32'hDEAD_BEEF, 0,0,0,0,0,0,0}, "empty_resp");
    chk("empty.resp_err_set", resp_err, 1'b1);
    cycle_chk('{0,0,0,0,32'h0, 0,0,0,0,0,0,0}, "empty_idle");
    chk("empty.resp_err_held", resp_err, 1'b1);
    for (int k = 0; k < 3; k++)
      cycle_chk('{1,0,1,0,32'h0, 1,0,1,0,0,0,k}, $sformatf("pre_rst%0d", k));
    chk("midrst.outstanding_3", outstanding, 3'd3);
    #2;
    resetn = 0;
    #1;
    chk("midrst.outstanding", outstanding, 3'd0);
    chk("midrst.s_req", s_req, 1'b0);
    chk("midrst.resp_err", resp_err, 1'b0);
    exp_q.delete();
    resetn = 1;
    s_data_ok = 1; s_rdata = 32'hCAFE_0001;
    #1;
    chk("postrst.s_req", s_req, 1'b0);
    chk("postrst.inst_data_ok", inst_data_ok, 1'b0);
    chk("postrst.data_data_ok", data_data_ok, 1'b0);
    @(posedge clk); #1;
    inst_req = 0; s_data_ok = 0;
    chk("postrst.resp_err", resp_err, 1'b1);
    chk("postrst.outstanding", outstanding, 3'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
